// File: rtl/image_stream_pkg.sv
// image_stream_pkg: shared FSM states, pixel types and BMP constants for the image stream blocks.
package image_stream_pkg;
    typedef enum logic [2:0] {IDLE, VBLANK, ACTIVE, HBLANK, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;
    typedef struct packed {
        pixel_t p1;
        pixel_t p0;
    } pair_t;
    localparam int BMP_HEADER_SIZE = 54;
endpackage

// File: rtl/image_stream_timing.sv
// image_stream_timing: blanking-delay, pair and line counters with terminal-count events.
module image_stream_timing
    import image_stream_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int START_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int PW          = $clog2(WIDTH / 2 + 1),
    parameter int LW          = $clog2(HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  state_t        state,
    output logic          delay_tc,
    output logic          pair_tc,
    output logic          line_tc,
    output logic [PW-1:0] pair,
    output logic [LW-1:0] line
);
    localparam int DMAX = START_DELAY > HSYNC_DELAY ? START_DELAY : HSYNC_DELAY;
    localparam int DW   = $clog2(DMAX + 1);

    logic [DW-1:0] delay;

    assign delay_tc = (state == VBLANK && delay == DW'(START_DELAY - 1)) ||
                      (state == HBLANK && delay == DW'(HSYNC_DELAY - 1));
    assign pair_tc  = state == ACTIVE && pair == PW'(WIDTH / 2 - 1);
    assign line_tc  = line == LW'(HEIGHT - 1);

    // The delay counter idles at zero so each blanking interval starts counting fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            delay <= '0;
            pair  <= '0;
            line  <= '0;
        end else begin
            delay <= (delay_tc || !(state inside {VBLANK, HBLANK})) ? '0 : delay + 1'b1;
            pair  <= (state != ACTIVE || pair_tc) ? '0 : pair + 1'b1;
            line  <= state == VBLANK ? '0 : (pair_tc && !line_tc) ? line + 1'b1 : line;
        end
    end
endmodule

// File: rtl/image_read_stream.sv
// image_read_stream: frame-buffer reader emitting two pixels per clock with hsync/vsync framing.
// Define READ_VFLIP_EN to read lines bottom-up (HEIGHT-1 down to 0) with identical timing.
module image_read_stream
    import image_stream_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int START_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int ADDR_W      = 18
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [47:0]       mem_rdata,
    output logic              vsync,
    output logic              hsync,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              ctrl_done,
    output logic              busy
);
    localparam int PW = $clog2(WIDTH / 2 + 1);
    localparam int LW = $clog2(HEIGHT + 1);

    state_t        state;
    logic          delay_tc, pair_tc, line_tc, rd_v;
    logic [PW-1:0] pair;
    logic [LW-1:0] line, row;
    pair_t         px;

    image_stream_timing #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .START_DELAY(START_DELAY),
        .HSYNC_DELAY(HSYNC_DELAY), .PW(PW), .LW(LW)
    ) u_timing (
        .clk(HCLK), .rst(HRESET), .state(state), .delay_tc(delay_tc),
        .pair_tc(pair_tc), .line_tc(line_tc), .pair(pair), .line(line)
    );

`ifdef READ_VFLIP_EN
    assign row = LW'(HEIGHT - 1) - line;
`else
    assign row = line;
`endif

    assign mem_rd_en = state == ACTIVE;
    assign mem_addr  = mem_rd_en ? ADDR_W'(row) * ADDR_W'(WIDTH / 2) + ADDR_W'(pair) : '0;
    assign busy      = state inside {VBLANK, ACTIVE, HBLANK};
    assign DATA_R0   = px.p0.r;
    assign DATA_G0   = px.p0.g;
    assign DATA_B0   = px.p0.b;
    assign DATA_R1   = px.p1.r;
    assign DATA_G1   = px.p1.g;
    assign DATA_B1   = px.p1.b;

    // rd_v marks the cycle mem_rdata is valid; DRAIN waits for it to clear before DONE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            vsync     <= 1'b0;
            ctrl_done <= 1'b0;
            rd_v      <= 1'b0;
            hsync     <= 1'b0;
            px        <= '0;
        end else begin
            vsync <= 1'b0;
            rd_v  <= mem_rd_en;
            hsync <= rd_v;
            px    <= rd_v ? mem_rdata : '0;
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= VBLANK;
                    vsync     <= 1'b1;
                    ctrl_done <= 1'b0;
                end
                VBLANK, HBLANK: if (delay_tc) state <= ACTIVE;
                ACTIVE: if (pair_tc) state <= line_tc ? DRAIN : HBLANK;
                DRAIN: if (!rd_v) begin
                    state     <= DONE;
                    ctrl_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
